// File: rtl/md_pkg.sv
// Shared constants, force types and state encoding for the MD host sequencer.
package md_pkg;

  localparam int N_ATOMS  = 32;
  localparam int MAX_NEI  = 4;
  localparam int NL_DEPTH = N_ATOMS * MAX_NEI;

  typedef logic signed [15:0] force_t;  // Q8.8

  typedef struct packed {
    force_t fx;
    force_t fy;
    force_t fz;
  } force_vec_t;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam int ERR_NL_RANGE = 0;
  localparam int ERR_TIMEOUT  = 1;
  localparam int ERR_RESULT   = 2;
  localparam int ERR_STRAY    = 3;

endpackage

// File: rtl/md_result_buf.sv
// Per-atom force result store with a written-bitmap for duplicate/missing detection.
module md_result_buf
  import md_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       we,
  input  logic [5:0] waddr,
  input  force_vec_t wdata,
  input  logic [5:0] raddr,
  output force_vec_t rdata,
  output logic       dup,
  output logic       full
);

  localparam int AW = $clog2(N_ATOMS);

  force_vec_t          mem [N_ATOMS];
  logic [N_ATOMS-1:0]  written;
  logic [N_ATOMS-1:0]  wr_mask;
  logic                we_ok;
  logic                rd_ok;
  logic [AW-1:0]       widx;
  logic [AW-1:0]       ridx;

  assign widx    = waddr[AW-1:0];
  assign ridx    = raddr[AW-1:0];
  assign we_ok   = we && ({1'b0, waddr} < 7'(N_ATOMS));
  assign wr_mask = we_ok ? (N_ATOMS'(1) << widx) : '0;
  assign dup     = we_ok && written[widx];
  // The write landing this cycle counts toward completeness
  assign full    = &(written | wr_mask);
  assign rd_ok   = ({1'b0, raddr} < 7'(N_ATOMS)) && written[ridx];
  assign rdata   = rd_ok ? mem[ridx] : '0;

  always_ff @(posedge clk) begin
    if (we_ok) mem[widx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) written <= '0;
    else               written <= written | wr_mask;
  end

endmodule

// File: rtl/md_host_seq.sv
// Host-side sequencer: loads the kernel neighbour list, starts the kernel,
// captures its force results and streams them back to the host in atom order.
module md_host_seq
  import md_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  output logic        busy,
  output logic        seq_done,
  output logic [3:0]  err,
  input  logic        nl_in_valid,
  output logic        nl_in_ready,
  input  logic [5:0]  nl_in_data,
  output logic        kern_nl_we,
  output logic [6:0]  kern_nl_waddr,
  output logic [5:0]  kern_nl_wdata,
  output logic        kern_start,
  input  logic        kern_out_we,
  input  logic [5:0]  kern_out_addr,
  input  logic [15:0] kern_out_fx,
  input  logic [15:0] kern_out_fy,
  input  logic [15:0] kern_out_fz,
  input  logic        kern_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [5:0]  res_addr,
  output logic [15:0] res_fx,
  output logic [15:0] res_fy,
  output logic [15:0] res_fz,
  output logic        res_last
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [2:0]    state;
  logic [6:0]    nl_cnt;
  logic [5:0]    drn_ptr;
  logic [TW-1:0] tmo_cnt;
  logic          nl_vld_p1;
  logic [6:0]    nl_addr_p1;
  logic [5:0]    nl_data_p1;
  logic          start_q;
  logic          done_q;
  logic [3:0]    err_q;
  logic [3:0]    err_set;
  logic          in_wait;
  logic          go_acc;
  logic          nl_hs;
  logic          tmo_hit;
  logic          buf_we;
  logic          buf_dup;
  logic          buf_full;
  force_vec_t    wr_vec;
  force_vec_t    rd_vec;

  assign in_wait = (state == ST_WAIT);
  assign go_acc  = (state == ST_IDLE) && go;
  assign nl_hs   = (state == ST_LOAD) && nl_in_valid;
  assign tmo_hit = (tmo_cnt >= TW'(TIMEOUT_CYC));
  assign buf_we  = in_wait && kern_out_we;
  assign wr_vec  = '{fx: force_t'(kern_out_fx), fy: force_t'(kern_out_fy), fz: force_t'(kern_out_fz)};

  always_comb begin
    err_set = '0;
    if (nl_hs && ({1'b0, nl_in_data} >= 7'(N_ATOMS))) err_set[ERR_NL_RANGE] = 1'b1;
    if (kern_out_we && !in_wait)                      err_set[ERR_STRAY]    = 1'b1;
    if (buf_we && buf_dup)                            err_set[ERR_RESULT]   = 1'b1;
    if (in_wait && kern_done && !buf_full)            err_set[ERR_RESULT]   = 1'b1;
    if (in_wait && !kern_done && tmo_hit)             err_set[ERR_TIMEOUT]  = 1'b1;
  end

  md_result_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_acc),
    .we    (buf_we),
    .waddr (kern_out_addr),
    .wdata (wr_vec),
    .raddr (drn_ptr),
    .rdata (rd_vec),
    .dup   (buf_dup),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      nl_cnt     <= '0;
      drn_ptr    <= '0;
      tmo_cnt    <= '0;
      nl_vld_p1  <= 1'b0;
      nl_addr_p1 <= '0;
      nl_data_p1 <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      err_q     <= (go_acc ? 4'b0 : err_q) | err_set;
      // NL beat -> kernel write port, one cycle later
      nl_vld_p1 <= nl_hs;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      if (nl_hs) begin
        nl_addr_p1 <= nl_cnt;
        nl_data_p1 <= nl_in_data;
        nl_cnt     <= nl_cnt + 7'd1;
      end
      case (state)
        ST_IDLE: begin
          if (go) begin
            nl_cnt <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (nl_hs && nl_cnt == 7'(NL_DEPTH - 1)) state <= ST_START;
        end
        ST_START: begin
          // First cycle carries the final NL write, second cycle pulses start
          start_q <= !start_q;
          tmo_cnt <= start_q ? TW'(1) : '0;
          if (start_q) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TW'(1);
          if (kern_done || tmo_hit) begin
            drn_ptr <= '0;
            state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (res_ready) begin
            if (drn_ptr == 6'(N_ATOMS - 1)) begin
              drn_ptr <= '0;
              done_q  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              drn_ptr <= drn_ptr + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign seq_done      = done_q;
  assign err           = err_q;
  assign nl_in_ready   = (state == ST_LOAD);
  assign kern_nl_we    = nl_vld_p1;
  assign kern_nl_waddr = nl_addr_p1;
  assign kern_nl_wdata = nl_data_p1;
  assign kern_start    = start_q;
  assign res_valid     = (state == ST_DRAIN);
  assign res_addr      = drn_ptr;
  assign res_fx        = res_valid ? rd_vec.fx : '0;
  assign res_fy        = res_valid ? rd_vec.fy : '0;
  assign res_fz        = res_valid ? rd_vec.fz : '0;
  assign res_last      = res_valid && (drn_ptr == 6'(N_ATOMS - 1));

endmodule

// File: doc/md_host_seq.md
Name: md_host_seq

Overview:
- Host-side sequencer on the opposite end of both md_kernel interfaces.
- Accepts a neighbour list from the host over a valid/ready stream and writes it into the kernel's NL write port, then pulses kernel start.
- Captures the kernel's per-atom force write stream into a local result buffer, detects protocol errors, and streams the results back to the host in atom order.

Parameters:
N_ATOMS, 32, atom count; sets the result buffer depth and address range
MAX_NEI, 4, neighbours per atom; NL_DEPTH = N_ATOMS*MAX_NEI = 128
TIMEOUT_CYC, 4096, maximum cycles from kern_start to kern_done before a timeout error

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
go  in  1  one-cycle command to begin a run; ignored while busy
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse after the last result handshake
err  out  4  sticky error code, cleared on accepted go
nl_in_valid  in  1  host NL beat valid
nl_in_ready  out  1  high in LOAD
nl_in_data  in  6  neighbour index, beats in order for address 0..127
kern_nl_we  out  1  kernel NL write enable
kern_nl_waddr  out  7  kernel NL write address
kern_nl_wdata  out  6  kernel NL write data
kern_start  out  1  one-cycle kernel start
kern_out_we  in  1  kernel result write strobe
kern_out_addr  in  6  kernel result atom index
kern_out_fx, kern_out_fy, kern_out_fz  in  16 each  signed Q8.8 forces
kern_done  in  1  kernel completion pulse
res_valid  out  1  result beat valid
res_ready  in  1  host accepts the result beat
res_addr  out  6  atom index of the beat
res_fx, res_fy, res_fz  out  16 each  signed Q8.8 forces
res_last  out  1  high with the beat for atom N_ATOMS-1

Behaviour:
- Reset, and any cycle with rst_n=0 including mid-run:
  - state to IDLE; all outputs 0; err to 0.
  - The nl beat counter, drain pointer, timeout counter and written-bitmap clear.
  - Result RAM contents are not cleared.
- FSM: IDLE -> LOAD -> START -> WAIT -> DRAIN -> IDLE.
- IDLE:
  - go=1 clears err, clears the bitmap and the nl counter, then enters LOAD.
  - go in any other state is ignored.
- LOAD:
  - nl_in_ready=1. On each handshake at cycle T, at T+1: kern_nl_we=1, waddr=count, wdata=data, count increments.
  - nl_in_data >= N_ATOMS sets err[0]; the value is forwarded unchanged.
  - The 128th handshake moves the FSM to START.
  - Required timing: the last handshake at T gives the write for address 127 at T+1 and kern_start=1 at T+2 only. WAIT is entered at T+3.
- WAIT:
  - The timeout counter starts at kern_start.
  - Each kern_out_we writes {fx,fy,fz} to RAM[addr] and sets bitmap[addr]. A write whose bitmap bit is already set also sets err[2].
  - kern_done moves the FSM to DRAIN. If the bitmap is not all ones at that point, set err[2].
  - If the counter reaches TIMEOUT_CYC without kern_done, set err[1] and go to DRAIN.
  - kern_out_we and kern_done in the same cycle: the write is captured before the bitmap check.
- Outside WAIT:
  - kern_out_we sets err[3]; RAM is unchanged.
  - kern_done is ignored.
- err[3:0] = {stray write, duplicate/missing result, timeout, NL index range}. err is sticky.
- DRAIN:
  - res_valid=1 with res_addr = pointer, starting at 0.
  - Data comes from an asynchronous RAM read. Entries whose bitmap bit is clear drain as 0.
  - The pointer advances on res_valid&&res_ready.
  - res_addr, res_f* and res_last must hold stable while res_ready=0.
  - After the handshake on atom N_ATOMS-1: next cycle seq_done=1 and state IDLE.
- Expected kernel behaviour: a force write precedes kern_done by one cycle; the nominal run takes about 1100 cycles.
- Widths:
  - counters are 7 bits (NL) and 6 bits (drain);
  - the timeout counter is clog2(TIMEOUT_CYC)+1 bits and saturates.

Decomposition:
- Package md_pkg:
  - N_ATOMS, MAX_NEI, NL_DEPTH;
  - the Q8.8 force typedef (logic signed [15:0]);
  - a force_vec_t struct {fx,fy,fz};
  - state enum;
  - err bit-position constants.
- One sub-module, md_result_buf:
  - 32-entry force_vec_t RAM with written-bitmap, clear and duplicate detection;
  - one write port, one asynchronous read port.

Test Plan:
- All four neighbours of atom i = (i+1)%32, host streams 128 beats, res_ready tied 1 -> 32 results with res_fx=+512, fy=fz=0, res_last on addr 31, seq_done once, err=0.
- Neighbours = (i-1)%32 with nl_in_valid and res_ready toggling randomly -> every res_fx=-512; kern_start exactly two cycles after the final NL beat; res data stable during stalls.
- Neighbours = (i+2)%32 -> every res_fx=+8; a wrap case at i=30/31 is included.
- Kernel model omits the write for atom 5 and duplicates atom 7 -> err=4'b0100; res for atom 5 drains as 0.
- Kernel model never asserts done -> err[1] set after 4096 cycles; drain proceeds; a stray kern_out_we during IDLE sets err[3].
- rst_n=0 during LOAD at beat 60, then go -> clean full run; no kern_start issued from the aborted run; results match the first scenario.
